// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and default sizing for the Wishbone-style port arbiter.
package wb_port_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int DEF_INPUTS = 4;
  localparam int DEF_DW     = 32;

endpackage

// File: rtl/wb_port_arbiter_and_or_mux.sv
// One-hot select AND-OR multiplexer: every lane is masked by its select bit and ORed.
module and_or_mux #(
  parameter int INPUTS = 4,
  parameter int DW     = 32
) (
  input  logic [INPUTS-1:0]    sel,
  input  logic [INPUTS*DW-1:0] in_data,
  output logic [DW-1:0]        out_data
);

  // Mask each lane with its select bit and merge
  always_comb begin
    out_data = {DW{1'b0}};
    for (int i = 0; i < INPUTS; i++) begin
      out_data = out_data | (in_data[i*DW +: DW] & {DW{sel[i]}});
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one registered output port among INPUTS requesters.
// Optional multi-beat locking is enabled by defining WB_ARB_LOCK_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int INPUTS = DEF_INPUTS,
  parameter int DW     = DEF_DW,
  localparam int SW    = $clog2(INPUTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INPUTS-1:0]    in_valid,
  input  logic [INPUTS-1:0]    in_last,
  input  logic [INPUTS*DW-1:0] in_data,
  output logic [INPUTS-1:0]    in_ready,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [DW-1:0]        out_data,
  output logic [SW-1:0]        out_src,
  input  logic                 out_ready
);

  logic [SW-1:0]     ptr_r;
  logic [SW-1:0]     ptr_nxt_s;
  logic [SW-1:0]     rr_cand_s;
  logic [SW-1:0]     rr_idx_s;
  logic              rr_found_s;
  logic [SW-1:0]     gidx_s;
  logic              found_s;
  logic [INPUTS-1:0] grant_s;
  logic              can_load_s;
  logic              accept_s;
  logic              acc_last_s;
  logic [DW-1:0]     mux_data_s;

  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] idx);
    if (int'(idx) == INPUTS - 1) begin
      return {SW{1'b0}};
    end else begin
      return idx + SW'(1);
    end
  endfunction

  // Round-robin search: first valid requester at or after ptr, wrapping to 0
  always_comb begin
    rr_idx_s   = {SW{1'b0}};
    rr_found_s = 1'b0;
    rr_cand_s  = {SW{1'b0}};
    for (int k = 0; k < INPUTS; k++) begin
      rr_cand_s = SW'((int'(ptr_r) + k) % INPUTS);
      if (!rr_found_s && in_valid[rr_cand_s]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = rr_cand_s;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

`ifdef WB_ARB_LOCK_EN
  arb_state_e    state_r;
  arb_state_e    state_nxt_s;
  logic [SW-1:0] lk_r;
  logic [SW-1:0] lk_nxt_s;

  // Grant source: round-robin in ARB, forced to the locked requester in LOCK
  always_comb begin
    gidx_s  = rr_idx_s;
    found_s = rr_found_s;
    case (state_r)
      ARB: begin
        gidx_s  = rr_idx_s;
        found_s = rr_found_s;
      end
      LOCK: begin
        gidx_s  = lk_r;
        found_s = in_valid[lk_r];
      end
      default: begin
        gidx_s  = rr_idx_s;
        found_s = rr_found_s;
      end
    endcase
  end

  // Next-state: enter LOCK on a non-last beat, release on the locked requester's last beat
  always_comb begin
    state_nxt_s = state_r;
    lk_nxt_s    = lk_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      ARB: begin
        if (accept_s && acc_last_s) begin
          ptr_nxt_s = wrap_inc(gidx_s);
        end else if (accept_s) begin
          state_nxt_s = LOCK;
          lk_nxt_s    = gidx_s;
        end else begin
          state_nxt_s = ARB;
        end
      end
      LOCK: begin
        if (accept_s && acc_last_s) begin
          state_nxt_s = ARB;
          ptr_nxt_s   = wrap_inc(lk_r);
        end else begin
          state_nxt_s = LOCK;
        end
      end
      default: begin
        state_nxt_s = ARB;
      end
    endcase
  end

  // Arbitration state and lock index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB;
      lk_r    <= {SW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      lk_r    <= lk_nxt_s;
    end
  end
`else
  assign gidx_s  = rr_idx_s;
  assign found_s = rr_found_s;

  // Without locking every accepted beat moves the pointer past its source
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (accept_s) begin
      ptr_nxt_s = wrap_inc(gidx_s);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end
`endif

  assign grant_s    = found_s ? (INPUTS'(1) << gidx_s) : {INPUTS{1'b0}};
  assign can_load_s = rst_n & (~out_valid | out_ready);
  assign in_ready   = grant_s & {INPUTS{can_load_s}};
  assign accept_s   = found_s & can_load_s;
  assign acc_last_s = in_last[gidx_s];

  and_or_mux #(
    .INPUTS (INPUTS),
    .DW     (DW)
  ) u_mux (
    .sel      (grant_s),
    .in_data  (in_data),
    .out_data (mux_data_s)
  );

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {SW{1'b0}};
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  // Output beat register: load on input transfer, clear on a drain with nothing new
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= {DW{1'b0}};
      out_src   <= {SW{1'b0}};
    end else if (accept_s) begin
      out_valid <= 1'b1;
      out_last  <= acc_last_s;
      out_data  <= mux_data_s;
      out_src   <= gidx_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule
